// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx
//   Serial bit-pattern transmitter. A start pulse in IDLE latches a PAT_W-bit
//   pattern, a repeat count and an inter-frame gap. The pattern is then sent
//   MSB-first, one bit per clock, once per frame. Idle gap cycles may separate
//   frames. This is the stimulus/loopback source for sequence-detector receivers.
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous reset, active low
//   start        in   1-cycle request, honoured only in IDLE
//   pattern      in   [PAT_W-1:0] pattern, latched on accepted start
//   repeat_cnt   in   [CNT_W-1:0] frame count, latched on start (0 -> 1)
//   gap_len      in   [GAP_W-1:0] idle cycles between frames (0 = back-to-back)
//   out_bit      out  serial data, 0 outside SEND
//   out_valid    out  out_bit carries pattern data
//   frame_start  out  high with the MSB of every frame
//   busy         out  transfer in progress (SEND or GAP)
//   done         out  1-cycle pulse after the last bit of the last frame
// All outputs are registered.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic [GAP_W-1:0] gap_len,
  output logic             out_bit,
  output logic             out_valid,
  output logic             frame_start,
  output logic             busy,
  output logic             done
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;
  localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(PAT_W - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t           state_q;
  logic [PAT_W-1:0] pat_q;
  logic [IDX_W-1:0] idx_q;      // index of the bit currently on out_bit
  logic [CNT_W-1:0] frames_q;   // frames left, including the one in flight
  logic [GAP_W-1:0] gap_q;      // latched gap length
  logic [GAP_W-1:0] gap_cnt_q;  // gap cycles left, including the current one
  logic             bit_q, valid_q, fs_q, busy_q, done_q;

  logic [IDX_W-1:0] idx_d;
  logic [CNT_W-1:0] frames_d;
  logic [GAP_W-1:0] gap_cnt_d;

  assign idx_d     = idx_q - IDX_W'(1);
  assign frames_d  = frames_q - CNT_W'(1);
  assign gap_cnt_d = gap_cnt_q - GAP_W'(1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      idx_q     <= '0;
      frames_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_q     <= 1'b0;
      valid_q   <= 1'b0;
      fs_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      fs_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          bit_q   <= 1'b0;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          if (start) begin
            pat_q    <= pattern;
            frames_q <= (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
            gap_q    <= gap_len;
            idx_q    <= IDX_MSB;
            bit_q    <= pattern[PAT_W-1];
            valid_q  <= 1'b1;
            fs_q     <= 1'b1;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (idx_q != '0) begin
            idx_q <= idx_d;
            bit_q <= pat_q[idx_d];
          end else if (frames_q > CNT_W'(1)) begin
            frames_q <= frames_d;
            if (gap_q == '0) begin
              // back-to-back: next frame's MSB immediately follows bit 0
              idx_q <= IDX_MSB;
              bit_q <= pat_q[PAT_W-1];
              fs_q  <= 1'b1;
            end else begin
              gap_cnt_q <= gap_q;
              bit_q     <= 1'b0;
              valid_q   <= 1'b0;
              state_q   <= GAP;
            end
          end else begin
            bit_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        GAP: begin
          // gap_cnt_q counts the gap cycle being shown; leave on the last one
          if (gap_cnt_q == GAP_W'(1)) begin
            idx_q   <= IDX_MSB;
            bit_q   <= pat_q[PAT_W-1];
            valid_q <= 1'b1;
            fs_q    <= 1'b1;
            state_q <= SEND;
          end else begin
            gap_cnt_q <= gap_cnt_d;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_bit     = bit_q;
  assign out_valid   = valid_q;
  assign frame_start = fs_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Testbench for seq_pattern_tx: a table of per-cycle {inputs, expected outputs}
// records applied in a loop, plus a hand-written asynchronous-reset sequence.
// Expected outputs are packed as {out_bit, out_valid, frame_start, busy, done}.
module tb_seq_pattern_tx;

  logic       clk, reset, start;
  logic [3:0] pattern, repeat_cnt, gap_len;
  logic       out_bit, out_valid, frame_start, busy, done;

  seq_pattern_tx #(.PAT_W(4), .CNT_W(4), .GAP_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern),
    .repeat_cnt(repeat_cnt), .gap_len(gap_len), .out_bit(out_bit),
    .out_valid(out_valid), .frame_start(frame_start), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       st;
    logic [3:0] pat;
    logic [3:0] rep;
    logic [3:0] gap;
    logic [4:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_pass = 0;
  int   n_tot  = 0;
  int   hits   = 0;
  logic [3:0] shreg = '0;

  // loopback detector: counts 1011 on valid bits (overlapping)
  always @(posedge clk) begin
    if (reset && out_valid) begin
      if ({shreg[2:0], out_bit} == 4'b1011) hits++;
      shreg <= {shreg[2:0], out_bit};
    end
  end

  function automatic logic [4:0] outs();
    return {out_bit, out_valid, frame_start, busy, done};
  endfunction

  task automatic check(input string name, input int idx, input logic [4:0] got,
                       input logic [4:0] want);
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s row %0d: got %b want %b", name, idx, got, want);
  endtask

  task automatic add(input string nm, input logic st, input logic [3:0] pat,
                     input logic [3:0] rep, input logic [3:0] gap, input logic [4:0] exp);
    vec_t v;
    v.name = nm; v.st = st; v.pat = pat; v.rep = rep; v.gap = gap; v.exp = exp;
    tbl.push_back(v);
  endtask

  // drive inputs at negedge, compare just after the following posedge
  task automatic step(input vec_t v, input int idx);
    @(negedge clk);
    start = v.st; pattern = v.pat; repeat_cnt = v.rep; gap_len = v.gap;
    @(posedge clk);
    #1 check(v.name, idx, outs(), v.exp);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], i);
    tbl.delete();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; pattern = '0; repeat_cnt = '0; gap_len = '0;
    repeat (2) @(posedge clk);
    #1 check("reset_state", 0, outs(), 5'b00000);
    @(negedge clk) reset = 1'b1;

    // T1: single frame 1011
    add("t1", 0, 4'b1011, 1, 0, 5'b00000);
    add("t1", 1, 4'b1011, 1, 0, 5'b11110);
    add("t1", 0, 4'b1011, 1, 0, 5'b01010);
    add("t1", 0, 4'b1011, 1, 0, 5'b11010);
    add("t1", 0, 4'b1011, 1, 0, 5'b11010);
    add("t1", 0, 4'b1011, 1, 0, 5'b00001);
    add("t1", 0, 4'b1011, 1, 0, 5'b00000);
    // T2: three back-to-back frames
    add("t2", 1, 4'b1011, 3, 0, 5'b11110);
    for (int f = 0; f < 3; f++) begin
      if (f != 0) add("t2", 0, 4'b1011, 3, 0, 5'b11110);
      add("t2", 0, 4'b1011, 3, 0, 5'b01010);
      add("t2", 0, 4'b1011, 3, 0, 5'b11010);
      add("t2", 0, 4'b1011, 3, 0, 5'b11010);
    end
    add("t2", 0, 4'b1011, 3, 0, 5'b00001);
    add("t2", 0, 4'b1011, 3, 0, 5'b00000);
    run_table();
    n_tot++;
    if (hits == 4) n_pass++;  // 1 hit from t1 + 3 from t2
    else $display("FAIL detector_hits: got %0d want 4", hits);

    // T3: two frames, gap of 2
    add("t3", 1, 4'b1011, 2, 2, 5'b11110);
    add("t3", 0, 4'b1011, 2, 2, 5'b01010);
    add("t3", 0, 4'b1011, 2, 2, 5'b11010);
    add("t3", 0, 4'b1011, 2, 2, 5'b11010);
    add("t3", 0, 4'b1011, 2, 2, 5'b00010);
    add("t3", 0, 4'b1011, 2, 2, 5'b00010);
    add("t3", 0, 4'b1011, 2, 2, 5'b11110);
    add("t3", 0, 4'b1011, 2, 2, 5'b01010);
    add("t3", 0, 4'b1011, 2, 2, 5'b11010);
    add("t3", 0, 4'b1011, 2, 2, 5'b11010);
    add("t3", 0, 4'b1011, 2, 2, 5'b00001);
    add("t3", 0, 4'b1011, 2, 2, 5'b00000);
    // T4: repeat 0 -> one frame; start while busy with new inputs is ignored
    add("t4", 1, 4'b1011, 0, 0, 5'b11110);
    add("t4", 1, 4'b0110, 3, 5, 5'b01010);
    add("t4", 0, 4'b0110, 3, 5, 5'b11010);
    add("t4", 0, 4'b0110, 3, 5, 5'b11010);
    add("t4", 0, 4'b0110, 3, 5, 5'b00001);
    add("t4", 0, 4'b0110, 3, 5, 5'b00000);
    add("t4", 0, 4'b0110, 3, 5, 5'b00000);
    // T_gap1: MSB-zero pattern, gap of 1
    add("tg1", 1, 4'b0101, 2, 1, 5'b01110);
    add("tg1", 0, 4'b0101, 2, 1, 5'b11010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b01010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b11010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b00010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b01110);
    add("tg1", 0, 4'b0101, 2, 1, 5'b11010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b01010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b11010);
    add("tg1", 0, 4'b0101, 2, 1, 5'b00001);
    add("tg1", 0, 4'b0101, 2, 1, 5'b00000);
    // T6: start held high through done -> restart right after done
    add("t6", 1, 4'b1100, 1, 0, 5'b11110);
    add("t6", 1, 4'b1100, 1, 0, 5'b11010);
    add("t6", 1, 4'b1100, 1, 0, 5'b01010);
    add("t6", 1, 4'b1100, 1, 0, 5'b01010);
    add("t6", 1, 4'b1100, 1, 0, 5'b00001);
    add("t6", 1, 4'b1100, 1, 0, 5'b11110);
    add("t6", 0, 4'b1100, 1, 0, 5'b11010);
    add("t6", 0, 4'b1100, 1, 0, 5'b01010);
    add("t6", 0, 4'b1100, 1, 0, 5'b01010);
    add("t6", 0, 4'b1100, 1, 0, 5'b00001);
    add("t6", 0, 4'b1100, 1, 0, 5'b00000);
    run_table();

    // T5: asynchronous reset mid-cycle during bit 2
    add("t5", 1, 4'b1011, 1, 0, 5'b11110);
    add("t5", 0, 4'b1011, 1, 0, 5'b01010);
    run_table();
    #3 reset = 1'b0;
    #1 check("t5_async_rst", 0, outs(), 5'b00000);
    @(posedge clk);
    #1 check("t5_in_rst", 1, outs(), 5'b00000);
    @(negedge clk) reset = 1'b1;
    add("t5b", 0, 4'b1011, 1, 0, 5'b00000);
    add("t5b", 0, 4'b1011, 1, 0, 5'b00000);
    add("t5b", 1, 4'b1110, 1, 0, 5'b11110);
    add("t5b", 0, 4'b1110, 1, 0, 5'b11010);
    add("t5b", 0, 4'b1110, 1, 0, 5'b11010);
    add("t5b", 0, 4'b1110, 1, 0, 5'b01010);
    add("t5b", 0, 4'b1110, 1, 0, 5'b00001);
    add("t5b", 0, 4'b1110, 1, 0, 5'b00000);
    run_table();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
